// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - ID-stage stall controller for data and MD-unit hazards (MD tracking under HAZARD_MD_UNIT_EN)
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [1:0]  id_tuse_rs,
  input  logic [1:0]  id_tuse_rt,
  input  logic        id_is_md,
  input  logic [4:0]  ex_wreg,
  input  logic [4:0]  mem_wreg,
  input  logic [1:0]  ex_tnew,
  input  logic [1:0]  mem_tnew,
  input  logic        ex_md_start,
  input  logic        ex_md_div,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_clr,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  logic        rs_hazard;
  logic        rt_hazard;
  logic        md_hazard;
  logic        stall;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // A source operand stalls when a pending writer's result arrives later than ID needs it.
  // Register 0 is never a real dependency; a tuse of 3 can never be exceeded by tnew.
  assign rs_hazard = (id_rs != 5'd0) &&
                     (((id_rs == ex_wreg)  && (ex_tnew  > id_tuse_rs)) ||
                      ((id_rs == mem_wreg) && (mem_tnew > id_tuse_rs)));

  assign rt_hazard = (id_rt != 5'd0) &&
                     (((id_rt == ex_wreg)  && (ex_tnew  > id_tuse_rt)) ||
                      ((id_rt == mem_wreg) && (mem_tnew > id_tuse_rt)));

`ifdef HAZARD_MD_UNIT_EN
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] md_cnt_q;
  logic [CNT_W-1:0] md_cnt_d;

  // Load the busy counter only from idle; a start while counting is dropped, otherwise count down.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (ex_md_start && (md_cnt_q == '0)) begin
      md_cnt_d = ex_md_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end
  end

  // MD busy counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  // While reset is held the stale count is hidden so only a fresh start shows as busy.
  assign md_busy   = ex_md_start | ((md_cnt_q != '0) & ~reset);
  assign md_hazard = id_is_md & md_busy;
`else
  logic unused_md;
  assign unused_md = ^{id_is_md, ex_md_start, ex_md_div,
                       32'(MULT_CYCLES), 32'(DIV_CYCLES), 32'(CNT_W)};

  assign md_busy   = 1'b0;
  assign md_hazard = 1'b0;
`endif

  assign stall     = (rs_hazard | rt_hazard | md_hazard) & ~reset;
  assign pc_en     = ~stall;
  assign if_id_en  = ~stall;
  assign id_ex_clr = stall;

  // Stall counter saturates at all ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

`ifdef HAZARD_MD_UNIT_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [1:0]  id_tuse_rs;
  logic [1:0]  id_tuse_rt;
  logic        id_is_md;
  logic [4:0]  ex_wreg;
  logic [4:0]  mem_wreg;
  logic [1:0]  ex_tnew;
  logic [1:0]  mem_tnew;
  logic        ex_md_start;
  logic        ex_md_div;
  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_clr;
  logic        md_busy;
  logic [31:0] stall_cnt;

  int total;
  int bad;
  logic [31:0] exp_cnt;

  hazard_stall_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_tuse_rs  (id_tuse_rs),
    .id_tuse_rt  (id_tuse_rt),
    .id_is_md    (id_is_md),
    .ex_wreg     (ex_wreg),
    .mem_wreg    (mem_wreg),
    .ex_tnew     (ex_tnew),
    .mem_tnew    (mem_tnew),
    .ex_md_start (ex_md_start),
    .ex_md_div   (ex_md_div),
    .pc_en       (pc_en),
    .if_id_en    (if_id_en),
    .id_ex_clr   (id_ex_clr),
    .md_busy     (md_busy),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_rs       = 5'd0;
    id_rt       = 5'd0;
    id_tuse_rs  = 2'd3;
    id_tuse_rt  = 2'd3;
    id_is_md    = 1'b0;
    ex_wreg     = 5'd0;
    mem_wreg    = 5'd0;
    ex_tnew     = 2'd0;
    mem_tnew    = 2'd0;
    ex_md_start = 1'b0;
    ex_md_div   = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    reset    = 1'b1;
    id_is_md = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({pc_en, if_id_en, id_ex_clr} !== 3'b110) begin
      bad++;
      $display("FAIL reset_outs: got %b want 110", {pc_en, if_id_en, id_ex_clr});
    end
    total++;
    if (md_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_md_busy: got %b want 0", md_busy);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    #1;
    total++;
    if (stall_cnt !== 32'd0) begin
      bad++;
      $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end
    exp_cnt = 32'd0;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_inputs();
    id_rs = 5'd5; id_tuse_rs = 2'd0; ex_wreg = 5'd5; ex_tnew = 2'd2;
    #1;
    total++;
    if ({pc_en, if_id_en, id_ex_clr} !== 3'b001) begin
      bad++;
      $display("FAIL load_use_ex: got %b want 001", {pc_en, if_id_en, id_ex_clr});
    end
    @(negedge clk);
    ex_wreg = 5'd0; mem_wreg = 5'd5; mem_tnew = 2'd1;
    #1;
    total++;
    if ({pc_en, if_id_en, id_ex_clr} !== 3'b001) begin
      bad++;
      $display("FAIL load_use_mem: got %b want 001", {pc_en, if_id_en, id_ex_clr});
    end
    @(negedge clk);
    mem_tnew = 2'd0;
    #1;
    total++;
    if ({pc_en, if_id_en, id_ex_clr} !== 3'b110) begin
      bad++;
      $display("FAIL load_use_clear: got %b want 110", {pc_en, if_id_en, id_ex_clr});
    end
    exp_cnt = exp_cnt + 32'd2;
    total++;
    if (stall_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    end
    // rt via EX: tnew above tuse stalls, tnew equal to tuse does not
    @(negedge clk);
    clear_inputs();
    id_rt = 5'd7; id_tuse_rt = 2'd1; ex_wreg = 5'd7; ex_tnew = 2'd2;
    #1;
    total++;
    if (id_ex_clr !== 1'b1) begin
      bad++;
      $display("FAIL rt_ex_stall: got %b want 1", id_ex_clr);
    end
    @(negedge clk);
    ex_tnew = 2'd1;
    #1;
    total++;
    if (id_ex_clr !== 1'b0) begin
      bad++;
      $display("FAIL rt_tnew_eq_tuse: got %b want 0", id_ex_clr);
    end
    exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic test_zero_and_nouse();
    @(negedge clk);
    clear_inputs();
    id_rt = 5'd0; id_tuse_rt = 2'd0; ex_wreg = 5'd0; ex_tnew = 2'd2;
    #1;
    total++;
    if (pc_en !== 1'b1) begin
      bad++;
      $display("FAIL reg_zero: got pc_en=%b want 1", pc_en);
    end
    @(negedge clk);
    id_rt = 5'd9; id_tuse_rt = 2'd3; ex_wreg = 5'd9; ex_tnew = 2'd2;
    mem_wreg = 5'd9; mem_tnew = 2'd2;
    #1;
    total++;
    if (pc_en !== 1'b1) begin
      bad++;
      $display("FAIL tuse_3: got pc_en=%b want 1", pc_en);
    end
    // rs and rt both hazard: one stall cycle counted once
    @(negedge clk);
    clear_inputs();
    id_rs = 5'd3; id_rt = 5'd3; id_tuse_rs = 2'd0; id_tuse_rt = 2'd0;
    ex_wreg = 5'd3; ex_tnew = 2'd2;
    #1;
    total++;
    if ({pc_en, if_id_en, id_ex_clr} !== 3'b001) begin
      bad++;
      $display("FAIL rs_rt_both: got %b want 001", {pc_en, if_id_en, id_ex_clr});
    end
    @(negedge clk);
    clear_inputs();
    exp_cnt = exp_cnt + 32'd1;
    #1;
    total++;
    if (stall_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL rs_rt_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_multiply();
    logic exp_busy;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      clear_inputs();
      id_is_md    = 1'b1;
      ex_md_start = (i == 0);
      ex_md_div   = 1'b0;
      exp_busy    = MD_EN && (i < 6);
      #1;
      total++;
      if (md_busy !== exp_busy) begin
        bad++;
        $display("FAIL mult_busy[%0d]: got %b want %b", i, md_busy, exp_busy);
      end
      total++;
      if (id_ex_clr !== exp_busy || pc_en !== !exp_busy) begin
        bad++;
        $display("FAIL mult_stall[%0d]: got clr=%b pc_en=%b want clr=%b", i, id_ex_clr, pc_en, exp_busy);
      end
    end
    @(negedge clk);
    clear_inputs();
    exp_cnt = exp_cnt + (MD_EN ? 32'd6 : 32'd0);
    #1;
    total++;
    if (stall_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL mult_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_divide_ignored_start();
    logic exp_busy;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      clear_inputs();
      ex_md_start = (i == 0) || (i == 3);
      ex_md_div   = 1'b1;
      exp_busy    = MD_EN ? (i < 11) : (i == 0 || i == 3) && 1'b0;
      #1;
      total++;
      if (md_busy !== exp_busy) begin
        bad++;
        $display("FAIL div_busy[%0d]: got %b want %b", i, md_busy, exp_busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clear_inputs();
      id_is_md    = 1'b1;
      ex_md_start = (i == 0);
      ex_md_div   = 1'b1;
    end
    @(negedge clk);
    clear_inputs();
    id_is_md = 1'b1;
    reset    = 1'b1;
    #1;
    total++;
    if ({pc_en, if_id_en, id_ex_clr} !== 3'b110) begin
      bad++;
      $display("FAIL reset_mid_outs: got %b want 110", {pc_en, if_id_en, id_ex_clr});
    end
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 32'd0;
    #1;
    total++;
    if (md_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_busy: got %b want 0", md_busy);
    end
    total++;
    if (stall_cnt !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_cnt: got %0d want 0", stall_cnt);
    end
    total++;
    if (pc_en !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_after_pc_en: got %b want 1", pc_en);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    clear_inputs();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.stall_cnt_q;
    #1;
    total++;
    if (stall_cnt !== 32'hFFFF_FFFE) begin
      bad++;
      $display("FAIL sat_preload: got %h want fffffffe", stall_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      id_rs = 5'd4; id_tuse_rs = 2'd0; ex_wreg = 5'd4; ex_tnew = 2'd1;
      #1;
      total++;
      if (stall_cnt !== ((i == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF)) begin
        bad++;
        $display("FAIL sat_step[%0d]: got %h", i, stall_cnt);
      end
    end
    @(negedge clk);
    clear_inputs();
    #1;
    total++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL sat_hold: got %h want ffffffff", stall_cnt);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    exp_cnt = 32'd0;
    reset   = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_zero_and_nouse();
    test_multiply();
    test_divide_ignored_start();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
